// File: rtl/fir_out_buffer.sv
// Output buffer for the FIR stage: captures the saturated FIR result one cycle
// after each qualified sample strobe into a FWFT FIFO and tracks clip/loss status.
module fir_out_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      iClk_12M,
    input  logic                      iRsn,
    input  logic                      iEnSample_300k,
    input  logic                      iEnDelay,
    input  logic signed [15:0]        iFirOut,
    input  logic                      iClrStat,
    output logic                      oValid,
    output logic signed [15:0]        oData,
    input  logic                      iReady,
    output logic [$clog2(DEPTH):0]    oLevel,
    output logic                      oOverflow,
    output logic [CNT_W-1:0]          oClipCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Stream handshake: oValid/oData present the FIFO head; a transfer happens on
    // every rising edge with oValid & iReady, and oData holds while oValid & !iReady.

    logic                     stb_q;
    logic                     stb_d;
    logic [PW-1:0]            wptr_q;
    logic [PW-1:0]            wptr_d;
    logic [PW-1:0]            rptr_q;
    logic [PW-1:0]            rptr_d;
    logic                     ovf_q;
    logic                     ovf_d;
    logic [CNT_W-1:0]         clip_q;
    logic [CNT_W-1:0]         clip_d;
    logic signed [15:0]       mem_q [DEPTH];

    logic                     empty;
    logic                     full;
    logic                     wr;
    logic                     rd;
    logic                     wr_ok;
    logic                     drop;
    logic                     is_clip;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign wr    = stb_q;
    assign rd    = oValid & iReady;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign wr_ok = wr & (~full | rd);
    assign drop  = wr & full & ~rd;

    assign is_clip = wr & ((iFirOut == 16'sh7FFF) || (iFirOut == -16'sh8000));

    always_comb begin
        stb_d  = iEnSample_300k & iEnDelay;
        wptr_d = wptr_q + PW'(wr_ok);
        rptr_d = rptr_q + PW'(rd);
        ovf_d  = ovf_q;
        clip_d = clip_q;
        if (iClrStat) begin
            ovf_d  = 1'b0;
            clip_d = '0;
        end else begin
            if (drop) begin
                ovf_d = 1'b1;
            end
            if (is_clip && (clip_q != {CNT_W{1'b1}})) begin
                clip_d = clip_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            stb_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            clip_q <= '0;
        end else begin
            stb_q  <= stb_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            clip_q <= clip_d;
        end
    end

    // Sample storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge iClk_12M) begin
        if (wr_ok) begin
            mem_q[wptr_q[AW-1:0]] <= iFirOut;
        end
    end

    assign oValid    = ~empty;
    assign oData     = mem_q[rptr_q[AW-1:0]];
    assign oLevel    = wptr_q - rptr_q;
    assign oOverflow = ovf_q;
    assign oClipCnt  = clip_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Randomized and directed bench for fir_out_buffer against a queue-based model.
module tb_fir_out_buffer;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        en_delay;
    logic [15:0] fir;
    logic        clr;
    logic        valid;
    logic [15:0] odata;
    logic        ready;
    logic [3:0]  level;
    logic        ovf;
    logic [7:0]  clip;

    fir_out_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iClk_12M       (clk),
        .iRsn           (rst_n),
        .iEnSample_300k (stb),
        .iEnDelay       (en_delay),
        .iFirOut        (fir),
        .iClrStat       (clr),
        .oValid         (valid),
        .oData          (odata),
        .iReady         (ready),
        .oLevel         (level),
        .oOverflow      (ovf),
        .oClipCnt       (clip)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard / reference model
    logic [15:0] exp_q[$];
    bit          m_ovf;
    int          m_clip;
    bit          m_pend;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(valid), 32'(exp_q.size() > 0));
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("clipcnt", 32'(clip), 32'(m_clip));
        if (exp_q.size() > 0) chk("data", 32'(odata), 32'(exp_q[0]));
    endtask

    // model of one rising edge given the inputs applied for this cycle
    task automatic model_edge(input bit s, input bit e, input logic [15:0] v,
                              input bit rdy, input bit c);
        bit was_full;
        bit do_rd;
        bit dropped;
        bit clipped;
        was_full = (exp_q.size() == DEPTH);
        do_rd    = (exp_q.size() > 0) && rdy;
        dropped  = 1'b0;
        clipped  = 1'b0;
        if (do_rd) void'(exp_q.pop_front());
        if (m_pend) begin
            clipped = (v == 16'h7FFF) || (v == 16'h8000);
            if (!was_full || do_rd) exp_q.push_back(v);
            else dropped = 1'b1;
        end
        if (c) begin
            m_ovf  = 1'b0;
            m_clip = 0;
        end else begin
            if (dropped) m_ovf = 1'b1;
            if (clipped && m_clip < CNT_MAX) m_clip++;
        end
        m_pend = s && e;
    endtask

    // driver: check current outputs, apply inputs, advance model
    task automatic cycle(input bit s, input bit e, input logic [15:0] v,
                         input bit rdy, input bit c);
        @(negedge clk);
        check_outputs();
        stb      = s;
        en_delay = e;
        fir      = v;
        ready    = rdy;
        clr      = c;
        model_edge(s, e, v, rdy, c);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom), rdy, 1'b0);
    endtask

    // strobe cycle then capture cycle carrying the sample value
    task automatic sample(input logic [15:0] v, input bit rdy, input bit c);
        cycle(1'b1, 1'b1, 16'($urandom), rdy, 1'b0);
        cycle(1'b0, 1'b0, v, rdy, c);
    endtask

    task automatic clear_stats();
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        idle(DEPTH + 3, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        stb = 1'b0; en_delay = 1'b0; ready = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_clip = 0;
        m_pend = 1'b0;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ovf = 1'b0; m_clip = 0; m_pend = 1'b0;
        rst_n = 1'b0; stb = 1'b0; en_delay = 1'b0; fir = '0; clr = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state and a single sample
        idle(2, 1'b0);
        sample(16'h1234, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("single_level", 32'(level), 32'd1);
        chk("single_data", 32'(odata), 32'h1234);
        drain();

        // fill to full, overflow on the ninth, drain in order
        for (int i = 1; i <= 8; i++) sample(16'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("full_level", 32'(level), 32'd8);
        sample(16'd9, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        drain();

        // full plus simultaneous read: no overflow, new sample stored
        clear_stats();
        for (int i = 0; i < 8; i++) sample(16'h100 + 16'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("fullrd_level", 32'(level), 32'd8);
        chk("fullrd_ovf", 32'(ovf), 32'd0);
        drain();

        // clip counting and saturation
        clear_stats();
        sample(16'h7FFF, 1'b1, 1'b0);
        sample(16'h8000, 1'b1, 1'b0);
        sample(16'h7FFE, 1'b1, 1'b0);
        sample(16'h8001, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("clip_two", 32'(clip), 32'd2);
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 1'b1, (i % 2) ? 16'h7FFF : 16'h8000, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("clip_sat", 32'(clip), 32'd255);

        // clear priority over an overflowing clipped write
        for (int i = 0; i < 8; i++) sample(16'h200 + 16'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        sample(16'h8000, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_clip", 32'(clip), 32'd0);
        chk("clr_level", 32'(level), 32'd8);
        drain();

        // async reset mid-stream
        for (int i = 0; i < 5; i++) sample(16'h300 + 16'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        async_reset();
        idle(1, 1'b0);
        sample(16'h4242, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("post_rst_level", 32'(level), 32'd1);
        drain();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            case ($urandom_range(0, 7))
                0:       v = 16'h7FFF;
                1:       v = 16'h8000;
                default: v = 16'($urandom);
            endcase
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, v,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
